// File: rtl/led_countdown_ctrl.sv
// Debounced multi-button start/pause/clear/direction controller driving an
// up/down tick counter onto active-low LEDs, with wrap or saturate-and-stop ends.
module led_countdown_ctrl #(
    parameter int unsigned       N_BTN           = 3,
    parameter int unsigned       LED_W           = 4,
    parameter int unsigned       DEBOUNCE_CYCLES = 5000000,
    parameter int unsigned       TICK_CYCLES     = 50000000,
    parameter logic [LED_W-1:0]  LOAD_VAL        = {LED_W{1'b1}},
    parameter bit                WRAP            = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [LED_W-1:0] leds_n,
    output logic [LED_W-1:0] count,
    output logic             running,
    output logic             done,
    output logic [N_BTN-1:0] btn_press
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0]  TK_LAST = TK_W'(TICK_CYCLES - 1);
    localparam logic [LED_W-1:0] CNT_MAX = {LED_W{1'b1}};
    localparam logic [LED_W-1:0] CNT_MIN = {LED_W{1'b0}};
    localparam logic [LED_W-1:0] CNT_ONE = LED_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] db;
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [N_BTN-1:0] accept_c;
    logic [N_BTN-1:0] press_c;

    state_t           state;
    state_t           state_nx;
    logic [TK_W-1:0]  tick;
    logic [TK_W-1:0]  tick_nx;
    logic [LED_W-1:0] count_nx;
    logic             dir;
    logic             dir_nx;
    logic [LED_W-1:0] step_val;
    logic             at_limit;
    logic             hits_end;

    // A pending level change is accepted once it has been stable long enough.
    always_comb begin
        accept_c = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            accept_c[i] = (sync2[i] != db[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    // Only a newly accepted low level (button pressed) counts as a press.
    assign press_c = accept_c & ~sync2;

    // Two-flop synchronizer and per-channel debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '1;
            sync2     <= '1;
            db        <= '1;
            btn_press <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1     <= btn_n;
            sync2     <= sync1;
            btn_press <= press_c;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (accept_c[i]) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Control state, tick counter, direction and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tick    <= '0;
            dir     <= 1'b0;
            count   <= LOAD_VAL;
            leds_n  <= ~LOAD_VAL;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            dir     <= dir_nx;
            count   <= count_nx;
            leds_n  <= ~count_nx;
            running <= (state_nx == S_RUN);
            done    <= (state_nx == S_DONE);
        end
    end

    // Next-state logic: clear beats start; direction toggles independently.
    always_comb begin
        state_nx = state;
        tick_nx  = tick;
        count_nx = count;
        dir_nx   = dir ^ press_c[2];
        step_val = dir ? (count + CNT_ONE) : (count - CNT_ONE);
        at_limit = dir ? (count == CNT_MAX) : (count == CNT_MIN);
        hits_end = dir ? (step_val == CNT_MAX) : (step_val == CNT_MIN);

        if (press_c[1]) begin
            state_nx = S_IDLE;
            count_nx = LOAD_VAL;
            tick_nx  = '0;
        end else if (press_c[0]) begin
            case (state)
                S_IDLE:  state_nx = S_RUN;
                S_RUN:   state_nx = S_PAUSE;
                S_PAUSE: state_nx = S_RUN;
                S_DONE: begin
                    state_nx = S_RUN;
                    count_nx = LOAD_VAL;
                    tick_nx  = '0;
                end
                default: state_nx = S_IDLE;
            endcase
        end else if (state == S_RUN) begin
            if (tick == TK_LAST) begin
                tick_nx = '0;
                if (WRAP) begin
                    count_nx = step_val;
                end else if (at_limit) begin
                    // Already pinned at the end (direction flipped onto it): stop there.
                    state_nx = S_DONE;
                end else begin
                    count_nx = step_val;
                    if (hits_end) begin
                        state_nx = S_DONE;
                    end
                end
            end else begin
                tick_nx = tick + TK_W'(1);
            end
        end else if (state != S_PAUSE) begin
            tick_nx = '0;
        end
    end

endmodule

// File: tb/tb_led_countdown_ctrl.sv
// Bench for led_countdown_ctrl: fixed scenario table, saturate sequence and
// randomized buttons/reset against a cycle-level reference model.
module tb_led_countdown_ctrl;

    localparam int D = 4;
    localparam int T = 8;
    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_RUN   = 2'd1;
    localparam logic [1:0] M_PAUSE = 2'd2;
    localparam logic [1:0] M_DONE  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_a = 4'hF;
    logic [2:0] btn_b = 3'h7;

    logic [3:0] leds_n_a, count_a, press_a;
    logic       running_a, done_a;
    logic [3:0] leds_n_b, count_b;
    logic [2:0] press_b;
    logic       running_b, done_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    led_countdown_ctrl #(
        .N_BTN(4), .LED_W(4), .DEBOUNCE_CYCLES(4), .TICK_CYCLES(8),
        .LOAD_VAL(4'hF), .WRAP(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_n(btn_a), .leds_n(leds_n_a), .count(count_a),
        .running(running_a), .done(done_a), .btn_press(press_a)
    );

    led_countdown_ctrl #(
        .N_BTN(3), .LED_W(4), .DEBOUNCE_CYCLES(4), .TICK_CYCLES(8),
        .LOAD_VAL(4'h2), .WRAP(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_n(btn_b), .leds_n(leds_n_b), .count(count_b),
        .running(running_b), .done(done_b), .btn_press(press_b)
    );

    // Reference model state: raw-pin delay line, accepted levels, run lengths
    // of disagreeing samples, and the controller's mode/count/tick/dir.
    typedef struct packed {
        logic [3:0]      s1;
        logic [3:0]      s2;
        logic [3:0]      db;
        logic [3:0]      press;
        logic [3:0][7:0] run;
        logic [3:0]      cnt;
        logic [1:0]      mode;
        logic            dir;
        logic [7:0]      tick;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t mstep(mst_t m, logic r, logic [3:0] b, bit wrap, logic [3:0] load);
        mst_t n;
        logic [3:0] acc;
        int nxt;
        n   = m;
        acc = 4'h0;
        if (r) begin
            n     = '0;
            n.s1  = 4'hF;
            n.s2  = 4'hF;
            n.db  = 4'hF;
            n.cnt = load;
            n.mode = M_IDLE;
            return n;
        end
        n.s1 = b;
        n.s2 = m.s1;
        for (int i = 0; i < 4; i++) begin
            if (m.s2[i] != m.db[i]) begin
                if (int'(m.run[i]) + 1 == D) begin
                    n.db[i]  = m.s2[i];
                    n.run[i] = 8'd0;
                    acc[i]   = ~m.s2[i];
                end else begin
                    n.run[i] = m.run[i] + 8'd1;
                end
            end else begin
                n.run[i] = 8'd0;
            end
        end
        n.press = acc;
        if (acc[2]) n.dir = ~m.dir;
        if (acc[1]) begin
            n.mode = M_IDLE;
            n.cnt  = load;
            n.tick = 8'd0;
        end else if (acc[0]) begin
            if (m.mode == M_IDLE || m.mode == M_PAUSE) n.mode = M_RUN;
            else if (m.mode == M_RUN) n.mode = M_PAUSE;
            else begin
                n.mode = M_RUN;
                n.cnt  = load;
                n.tick = 8'd0;
            end
        end else if (m.mode == M_RUN) begin
            if (int'(m.tick) + 1 == T) begin
                n.tick = 8'd0;
                nxt = m.dir ? int'(m.cnt) + 1 : int'(m.cnt) - 1;
                if (wrap) begin
                    n.cnt = 4'((nxt + 16) % 16);
                end else if (nxt <= 0) begin
                    n.cnt  = 4'h0;
                    n.mode = M_DONE;
                end else if (nxt >= 15) begin
                    n.cnt  = 4'hF;
                    n.mode = M_DONE;
                end else begin
                    n.cnt = 4'(nxt);
                end
            end else begin
                n.tick = m.tick + 8'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [13:0] mview(mst_t m);
        return {m.cnt, ~m.cnt, m.mode == M_RUN, m.mode == M_DONE, m.press};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        ma <= mstep(ma, rst, btn_a, 1'b1, 4'hF);
        mb <= mstep(mb, rst, {1'b1, btn_b}, 1'b0, 4'h2);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a", 16'({count_a, leds_n_a, running_a, done_a, press_a}), 16'(mview(ma)));
            check("model_b", 16'({count_b, leds_n_b, running_b, done_b, 1'b0, press_b}), 16'(mview(mb)));
        end
    end

    typedef struct {
        logic       r;
        logic [3:0] btn;
        int         n;
        logic [3:0] cnt;
        logic       run;
        logic       dn;
        logic [3:0] press;
    } vec_t;

    vec_t tbl[$];

    // Hold inputs for n edges, OR together press pulses seen, then check.
    task automatic apply(input vec_t v, input bit sel, input string name);
        logic [3:0] seen;
        logic [15:0] act;
        @(negedge clk);
        rst = v.r;
        if (sel) btn_b = v.btn[2:0];
        else     btn_a = v.btn;
        seen = 4'h0;
        repeat (v.n) begin
            @(posedge clk);
            #1;
            seen |= sel ? {1'b0, press_b} : press_a;
        end
        if (sel) act = 16'({count_b, leds_n_b, running_b, done_b, seen});
        else     act = 16'({count_a, leds_n_a, running_a, done_a, seen});
        check(name, act, 16'({v.cnt, ~v.cnt, v.run, v.dn, v.press}));
    endtask

    task automatic apply_b(input logic [2:0] b, input int n, input logic [3:0] c,
                           input logic run, input logic dn, input logic [3:0] p,
                           input string name);
        vec_t v;
        v = '{1'b0, {1'b1, b}, n, c, run, dn, p};
        apply(v, 1'b1, name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // {rst, btn_n, edges, count, running, done, press seen}
        tbl.push_back('{1'b1, 4'hF,  2, 4'hF, 1'b0, 1'b0, 4'h0}); // reset
        tbl.push_back('{1'b0, 4'hE,  3, 4'hF, 1'b0, 1'b0, 4'h0}); // bounce
        tbl.push_back('{1'b0, 4'hF,  6, 4'hF, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hE,  6, 4'hF, 1'b1, 1'b0, 4'h1}); // start
        tbl.push_back('{1'b0, 4'hE,  1, 4'hF, 1'b1, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hF,  6, 4'hF, 1'b1, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hF,  1, 4'hE, 1'b1, 1'b0, 4'h0}); // first step
        tbl.push_back('{1'b0, 4'hE,  6, 4'hE, 1'b0, 1'b0, 4'h1}); // pause
        tbl.push_back('{1'b0, 4'hF, 40, 4'hE, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hE,  6, 4'hE, 1'b1, 1'b0, 4'h1}); // resume
        tbl.push_back('{1'b0, 4'hF,  2, 4'hE, 1'b1, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hF,  1, 4'hD, 1'b1, 1'b0, 4'h0}); // partial tick
        tbl.push_back('{1'b0, 4'hB,  6, 4'hD, 1'b1, 1'b0, 4'h4}); // dir up
        tbl.push_back('{1'b0, 4'hF,  2, 4'hE, 1'b1, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hF,  8, 4'hF, 1'b1, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hF,  8, 4'h0, 1'b1, 1'b0, 4'h0}); // wrap
        tbl.push_back('{1'b0, 4'hF,  8, 4'h1, 1'b1, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hC,  6, 4'hF, 1'b0, 1'b0, 4'h3}); // clear+start
        tbl.push_back('{1'b0, 4'hF,  6, 4'hF, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'h7,  6, 4'hF, 1'b0, 1'b0, 4'h8}); // export only
        tbl.push_back('{1'b0, 4'hF,  6, 4'hF, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hA,  6, 4'hF, 1'b1, 1'b0, 4'h5}); // start+dir
        tbl.push_back('{1'b0, 4'hF, 32, 4'hB, 1'b1, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hE,  3, 4'hB, 1'b1, 1'b0, 4'h0});
        tbl.push_back('{1'b1, 4'hE,  1, 4'hF, 1'b0, 1'b0, 4'h0}); // reset mid-run
        tbl.push_back('{1'b0, 4'hE,  4, 4'hF, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hE,  2, 4'hF, 1'b1, 1'b0, 4'h1});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 1'b0, $sformatf("row_%0d", i));
            if (i == 0) chk_en = 1'b1;
        end

        // Saturating instance: down to 0, restart, then up to all-ones, then clear.
        apply_b(3'h6,  6, 4'h2, 1'b1, 1'b0, 4'h1, "b_start");
        apply_b(3'h7,  8, 4'h1, 1'b1, 1'b0, 4'h0, "b_step1");
        apply_b(3'h7,  7, 4'h1, 1'b1, 1'b0, 4'h0, "b_hold");
        apply_b(3'h7,  1, 4'h0, 1'b0, 1'b1, 4'h0, "b_done_edge");
        apply_b(3'h7, 16, 4'h0, 1'b0, 1'b1, 4'h0, "b_done_hold");
        apply_b(3'h6,  6, 4'h2, 1'b1, 1'b0, 4'h1, "b_restart");
        apply_b(3'h3,  6, 4'h2, 1'b1, 1'b0, 4'h4, "b_dir_up");
        apply_b(3'h7,  2, 4'h3, 1'b1, 1'b0, 4'h0, "b_up_step");
        apply_b(3'h7, 96, 4'hF, 1'b0, 1'b1, 4'h0, "b_done_up");
        apply_b(3'h5,  6, 4'h2, 1'b0, 1'b0, 4'h2, "b_clear_done");

        // Randomized buttons with occasional reset, checked by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) btn_a[i] = ~btn_a[i];
            end
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) btn_b[i] = ~btn_b[i];
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
